call_stack: RTL and testbench

- Hardware return-address stack: the storage end of the call/return protocol driven by the program counter.
- On a subroutine call the fetch side pushes the current PC. On a return it pops the entry and receives the ready-made return target, saved PC + 1.
- Replaces single-level return storage with a DEPTH-deep LIFO. Sits beside the PC in the fetch stage.

---
 rtl/call_stack_if.sv | 29 ++
 rtl/call_stack.sv | 95 +++++++++
 tb/tb_call_stack.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/call_stack_if.sv
// Call/return handshake between the fetch-stage PC logic and the return-address stack.
interface call_stack_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DEPTH  = 8
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic              clear;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] push_addr;
    logic [ADDR_W-1:0] top;
    logic [ADDR_W-1:0] ret_addr;
    logic [PTR_W:0]    count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    modport master (
        output clear, push, pop, push_addr,
        input  top, ret_addr, count, empty, full, overflow, underflow
    );

    modport slave (
        input  clear, push, pop, push_addr,
        output top, ret_addr, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/call_stack.sv
// DEPTH-deep hardware return-address stack; a circular array that overwrites the oldest
// entry on overflow and hands back the saved PC + 1 as the return target.
module call_stack #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DEPTH  = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    call_stack_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wp_q, wp_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              mem_we;
    logic [PTR_W-1:0]  mem_waddr;
    logic [PTR_W-1:0]  top_idx;
    logic              is_empty;
    logic              is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == FULL_CNT);
    assign top_idx  = wp_q - 1'b1;

    always_comb begin
        wp_d      = wp_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        mem_we    = 1'b0;
        mem_waddr = wp_q;
        if (bus.clear) begin
            wp_d    = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (bus.push && (!bus.pop || is_empty)) begin
            // Plain push; a push+pop on an empty stack degrades to this.
            mem_we = 1'b1;
            wp_d   = wp_q + 1'b1;
            if (is_full) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
            if (bus.pop) begin
                unf_d = 1'b1;
            end
        end else if (bus.push && bus.pop) begin
            // Tail call: replace the top entry in place.
            mem_we    = 1'b1;
            mem_waddr = top_idx;
        end else if (bus.pop) begin
            if (is_empty) begin
                unf_d = 1'b1;
            end else begin
                wp_d    = top_idx;
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is not reset; the write is still suppressed while reset is held.
    always_ff @(posedge clock) begin
        if (mem_we && reset_n) begin
            mem[mem_waddr] <= bus.push_addr;
        end
    end

    assign bus.top       = is_empty ? '0 : mem[top_idx];
    assign bus.ret_addr  = bus.top + 1'b1;
    assign bus.count     = count_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
endmodule

// File: tb/tb_call_stack.sv
// Randomized and directed checks of call_stack against a queue-based LIFO model.
module tb_call_stack;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DEPTH  = 8;

    logic clock;
    logic reset_n;

    call_stack_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    call_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Model: queue back is the top; the front is dropped when a push overflows.
    int m_q[$];
    bit m_ovf;
    bit m_unf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int m_top();
        return (m_q.size() > 0) ? m_q[$] : 0;
    endfunction

    function automatic int m_ret();
        return (m_top() + 1) % (1 << ADDR_W);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_edge(input bit c, input bit p, input bit o, input int a);
        if (c) begin
            model_reset();
        end else if (p && o && m_q.size() > 0) begin
            m_q[m_q.size() - 1] = a;
        end else if (p) begin
            if (o) m_unf = 1'b1;
            if (m_q.size() == DEPTH) begin
                void'(m_q.pop_front());
                m_ovf = 1'b1;
            end
            m_q.push_back(a);
        end else if (o) begin
            if (m_q.size() == 0) m_unf = 1'b1;
            else void'(m_q.pop_back());
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".top"},   32'(bus.top),       32'(m_top()));
        check({tag, ".ret"},   32'(bus.ret_addr),  32'(m_ret()));
        check({tag, ".count"}, 32'(bus.count),     32'(m_q.size()));
        check({tag, ".empty"}, 32'(bus.empty),     32'(m_q.size() == 0));
        check({tag, ".full"},  32'(bus.full),      32'(m_q.size() == DEPTH));
        check({tag, ".ovf"},   32'(bus.overflow),  32'(m_ovf));
        check({tag, ".unf"},   32'(bus.underflow), 32'(m_unf));
    endtask

    // Called just after a falling edge; applies one cycle and checks after the next fall.
    task automatic step(input string tag, input bit c, input bit p, input bit o, input int a);
        bus.clear     = c;
        bus.push      = p;
        bus.pop       = o;
        bus.push_addr = ADDR_W'(a);
        #1;
        if (o) check({tag, ".ret_pre"}, 32'(bus.ret_addr), 32'(m_ret()));
        @(posedge clock);
        model_edge(c, p, o, a);
        @(negedge clock);
        check_all(tag);
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.clear     = 1'b0;
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.push_addr = '0;
        model_reset();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check_all("reset");
        check("reset.ret_lit", 32'(bus.ret_addr), 32'h001);

        // Nested calls and returns.
        step("call", 0, 1, 0, 'h010);
        step("call", 0, 1, 0, 'h020);
        step("call", 0, 1, 0, 'h030);
        check("nest.top", 32'(bus.top), 32'h030);
        check("nest.ret", 32'(bus.ret_addr), 32'h031);
        for (int i = 0; i < 3; i++) step("ret", 0, 0, 1, 0);
        check("nest.unf", 32'(bus.underflow), 32'h0);

        // Overflow wrap: 9 pushes, 8 good pops, then one underflowing pop.
        for (int i = 0; i < 9; i++) step("ovf_push", 0, 1, 0, 'h100 + i);
        check("ovf.top", 32'(bus.top), 32'h108);
        check("ovf.flag", 32'(bus.overflow), 32'h1);
        for (int i = 0; i < 8; i++) begin
            check("ovf.pop_top", 32'(bus.top), 32'(32'h108 - i));
            step("ovf_pop", 0, 0, 1, 0);
        end
        step("unf_pop", 0, 0, 1, 0);
        check("unf.flag", 32'(bus.underflow), 32'h1);

        // Tail call on a two-deep stack, then on an empty stack.
        step("clr", 1, 0, 0, 0);
        step("tc_fill", 0, 1, 0, 'h050);
        step("tc_fill", 0, 1, 0, 'h060);
        step("tc", 0, 1, 1, 'h070);
        check("tc.top", 32'(bus.top), 32'h070);
        step("tc_pop", 0, 0, 1, 0);
        check("tc.after", 32'(bus.top), 32'h050);
        step("tc_pop", 0, 0, 1, 0);
        step("tc_empty", 0, 1, 1, 'h0AB);
        check("tc_empty.unf", 32'(bus.underflow), 32'h1);

        // Wrap arithmetic and clear priority.
        step("clr", 1, 0, 0, 0);
        step("wrap", 0, 1, 0, 'h7FF);
        check("wrap.ret", 32'(bus.ret_addr), 32'h000);
        for (int i = 0; i < 9; i++) step("clr_fill", 0, 1, 0, 'h200 + i);
        step("clr_push", 1, 1, 0, 'h333);
        check("clr.count", 32'(bus.count), 32'h0);

        // Asynchronous reset between edges with a push in flight.
        for (int i = 0; i < 5; i++) step("rst_fill", 0, 1, 0, 'h400 + i);
        bus.push      = 1'b1;
        bus.push_addr = ADDR_W'('h4AA);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst.count", 32'(bus.count), 32'h0);
        check("rst.ovf", 32'(bus.overflow), 32'h0);
        check("rst.unf", 32'(bus.underflow), 32'h0);
        bus.push = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        step("rst_idle", 0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            bit c, p, o;
            c = ($urandom_range(0, 39) == 0);
            p = ($urandom_range(0, 9) < 5);
            o = ($urandom_range(0, 9) < 4);
            step("rand", c, p, o, int'($urandom_range(0, (1 << ADDR_W) - 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
